// File: rtl/codma_pkg.sv
// Shared types for the CODMA bus arbiter slice.
package codma_pkg;

    localparam int CODMA_N_REQ  = 4;
    localparam int CODMA_ADDR_W = 32;
    localparam int CODMA_DATA_W = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    typedef logic [$clog2(CODMA_N_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic                    read;
        logic                    write;
        logic [CODMA_ADDR_W-1:0] addr;
        logic [CODMA_DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/codma_id_fifo.sv
// In-order FIFO of requester IDs for outstanding bus reads.
module codma_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a full FIFO can still accept when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/codma_bus_arbiter.sv
// Round-robin arbiter for the CODMA bus master port with in-order read return.
// Define CODMA_ARB_WATCHDOG_EN to add the grant watchdog and timeout_o.
module codma_bus_arbiter
    import codma_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
`ifdef CODMA_ARB_WATCHDOG_EN
    , parameter int WDOG_LIMIT = 255
`endif
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [N_REQ-1:0]    req_read_i,
    input  logic [N_REQ-1:0]    req_write_i,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    output logic [N_REQ-1:0]    req_grant_o,
    output logic [N_REQ-1:0]    req_rvalid_o,
    output logic [DATA_W-1:0]   req_rdata_o,
    output logic                bus_read_o,
    output logic                bus_write_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_grant_i,
    input  logic                bus_rvalid_i,
    input  logic [DATA_W-1:0]   bus_rdata_i,
    output logic                proto_err_o
`ifdef CODMA_ARB_WATCHDOG_EN
    , output logic              timeout_o
`endif
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_ISSUE = ISSUE;

    logic [0:0]       state;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  pick;
    logic [N_REQ-1:0] elig;
    logic             any;
    logic             granted;
    logic             push;
    logic             pop;
    logic [ID_W-1:0]  head;
    logic             full;
    logic             empty;

    function automatic logic [ID_W-1:0] rr_pick(
        input logic [N_REQ-1:0] e,
        input logic [ID_W-1:0]  p
    );
        logic [ID_W-1:0] w;
        logic            found;
        int              idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(p) + i) % N_REQ;
            if (!found && e[idx]) begin
                w     = ID_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // a read+write request is treated as a read, so it must wait for FIFO room
    assign elig    = (req_write_i & ~req_read_i)
                   | (req_read_i & {N_REQ{~full}});
    assign any     = |elig;
    assign pick    = rr_pick(elig, rr_ptr);
    assign granted = (state == ST_ISSUE) && bus_grant_i;
    assign push    = granted && bus_read_o;
    assign pop     = bus_rvalid_i && !empty;

    always_comb begin
        req_grant_o  = '0;
        req_rvalid_o = '0;
        req_rdata_o  = '0;
        if (granted) req_grant_o[id] = 1'b1;
        if (pop) begin
            req_rvalid_o[head] = 1'b1;
            req_rdata_o        = bus_rdata_i;
        end
    end

    codma_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk   (clk_i),
        .rst   (reset_i),
        .push  (push),
        .din   (id),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            id          <= '0;
            rr_ptr      <= '0;
            bus_read_o  <= 1'b0;
            bus_write_o <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            proto_err_o <= 1'b0;
        end else begin
            if ((bus_rvalid_i && empty) || (bus_grant_i && state == ST_IDLE))
                proto_err_o <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        id          <= pick;
                        bus_read_o  <= req_read_i[pick];
                        bus_write_o <= req_write_i[pick] & ~req_read_i[pick];
                        bus_addr_o  <= req_addr_i[pick*ADDR_W +: ADDR_W];
                        bus_wdata_o <= req_wdata_i[pick*DATA_W +: DATA_W];
                        state       <= ST_ISSUE;
                        if (req_read_i[pick] && req_write_i[pick])
                            proto_err_o <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus_grant_i) begin
                        rr_ptr      <= (id == ID_W'(N_REQ-1)) ? '0 : id + 1'b1;
                        bus_read_o  <= 1'b0;
                        bus_write_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CODMA_ARB_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        timeout_r;
    logic        wdog_hit;

    // the count equals completed ungranted ISSUE cycles, so +1 is the current one
    assign wdog_hit  = (state == ST_ISSUE) && (int'(wdog_cnt) + 1 >= WDOG_LIMIT);
    assign timeout_o = timeout_r | wdog_hit;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wdog_cnt  <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state == ST_IDLE && any)
                wdog_cnt <= '0;
            else if (state == ST_ISSUE && !bus_grant_i && wdog_cnt != 16'hFFFF)
                wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_hit) timeout_r <= 1'b1;
        end
    end
`endif

endmodule
